// File: rtl/led_cmd_pwm_pkg.sv
// ---------------------------------------------------------------------------
// led_cmd_pwm_pkg
// Shared definitions for the LED command decoder and its PWM channel bank:
// frame field widths, command opcodes, FSM state and action encodings, and
// a helper that maps a raw command byte onto an action.
// ---------------------------------------------------------------------------
package led_cmd_pwm_pkg;

    localparam int CMD_BITS         = 8;
    localparam int ADDR_BITS        = 8;
    localparam int PAYLOAD_BITS     = 8;
    localparam int FRAME_BITS       = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;
    localparam int DEFAULT_NUM_LEDS = 8;
    localparam int BRIGHT_W         = 7;

    // The PWM counter runs 0..PWM_TOP, giving a 127-tick period
    localparam logic [BRIGHT_W-1:0] PWM_TOP = 7'd126;

    localparam logic [CMD_BITS-1:0] CMD_NOP     = 8'h00;
    localparam logic [CMD_BITS-1:0] CMD_LED_SET = 8'h01;
    localparam logic [CMD_BITS-1:0] CMD_LED_GET = 8'h02;
    localparam logic [CMD_BITS-1:0] CMD_ALL_OFF = 8'h03;

    typedef enum logic [1:0] {
        LC_IDLE   = 2'd0,
        LC_DECODE = 2'd1,
        LC_EXEC   = 2'd2
    } lc_state_t;

    typedef enum logic [2:0] {
        ACT_NOP     = 3'd0,
        ACT_SET     = 3'd1,
        ACT_GET     = 3'd2,
        ACT_ALL_OFF = 3'd3,
        ACT_BAD     = 3'd4
    } lc_action_t;

    // Unknown opcodes collapse onto ACT_BAD so EXEC only has to count them
    function automatic lc_action_t classifyCmd(input logic [CMD_BITS-1:0] cmd);
        case (cmd)
            CMD_NOP:     return ACT_NOP;
            CMD_LED_SET: return ACT_SET;
            CMD_LED_GET: return ACT_GET;
            CMD_ALL_OFF: return ACT_ALL_OFF;
            default:     return ACT_BAD;
        endcase
    endfunction

endpackage

// File: rtl/pwm_channel_bank.sv
// ---------------------------------------------------------------------------
// pwm_channel_bank
// Shared prescaler and 7-bit PWM counter driving NUM_LEDS comparators.
// Brightness is sampled into shadow registers only when the PWM counter
// wraps, so a new value never cuts a period short or stretches it.
//
// Ports:
//   sysclk    in   system clock
//   rst       in   asynchronous active-high reset
//   i_bright  in   packed brightness bus, 7 bits per channel, channel 0 lowest
//   o_leds    out  registered PWM outputs, bit 0 is channel 0
// ---------------------------------------------------------------------------
module pwm_channel_bank
    import led_cmd_pwm_pkg::*;
#(
    parameter int NUM_LEDS = DEFAULT_NUM_LEDS,
    parameter int PWM_DIV  = 4
) (
    input  logic                         sysclk,
    input  logic                         rst,
    input  logic [NUM_LEDS*BRIGHT_W-1:0] i_bright,
    output logic [NUM_LEDS-1:0]          o_leds
);

    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);

    logic [PRE_W-1:0]                    r_pre;
    logic [BRIGHT_W-1:0]                 r_pwmCnt;
    logic [NUM_LEDS-1:0][BRIGHT_W-1:0]   r_shadow;
    logic [NUM_LEDS-1:0]                 r_leds;
    logic                                w_tick;

    assign w_tick = (r_pre == PRE_LAST);
    assign o_leds = r_leds;

    // Prescaler, PWM counter, period-boundary shadow load and comparators.
    // The comparator output is registered so the LED pins never see the
    // compare logic directly.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_pre    <= '0;
            r_pwmCnt <= '0;
            r_shadow <= '0;
            r_leds   <= '0;
        end else begin
            if (w_tick) begin
                r_pre <= '0;
                if (r_pwmCnt == PWM_TOP) begin
                    r_pwmCnt <= '0;
                    r_shadow <= i_bright;
                end else begin
                    r_pwmCnt <= r_pwmCnt + 7'd1;
                end
            end else begin
                r_pre <= r_pre + PRE_W'(1);
            end
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_leds[i] <= (r_pwmCnt < r_shadow[i]);
            end
        end
    end

endmodule

// File: rtl/led_cmd_pwm.sv
// ---------------------------------------------------------------------------
// led_cmd_pwm
// Decodes SPI frames {cmd, addr, payload} from the slave receiver, keeps one
// 7-bit brightness register per LED, builds the readback frame for the next
// transfer and counts rejected frames. PWM generation lives in
// pwm_channel_bank.
//
// Ports:
//   sysclk    in   system clock
//   rst       in   asynchronous active-high reset
//   rx_dv     in   one-cycle strobe, rx_frame valid
//   rx_frame  in   {cmd, addr, payload}
//   tx_frame  out  readback frame
//   tx_load   out  one-cycle strobe when tx_frame changes
//   busy      out  high while a frame is being processed
//   err_cnt   out  saturating count of rejected frames
//   leds      out  PWM outputs, bit 0 is led1
// ---------------------------------------------------------------------------
module led_cmd_pwm
    import led_cmd_pwm_pkg::*;
#(
    parameter int NUM_LEDS = DEFAULT_NUM_LEDS,
    parameter int PWM_DIV  = 4,
    parameter int FRAME_W  = FRAME_BITS
) (
    input  logic               sysclk,
    input  logic               rst,
    input  logic               rx_dv,
    input  logic [FRAME_W-1:0] rx_frame,
    output logic [FRAME_W-1:0] tx_frame,
    output logic               tx_load,
    output logic               busy,
    output logic [7:0]         err_cnt,
    output logic [NUM_LEDS-1:0] leds
);

    localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    lc_state_t                          r_state;
    lc_state_t                          w_nextState;
    logic [CMD_BITS-1:0]                r_cmd;
    logic [ADDR_BITS-1:0]               r_addr;
    logic [BRIGHT_W-1:0]                r_level;
    lc_action_t                         r_action;
    logic                               r_addrOk;
    logic [NUM_LEDS-1:0][BRIGHT_W-1:0]  r_bright;
    logic [FRAME_W-1:0]                 r_txFrame;
    logic                               r_txLoad;
    logic [7:0]                         r_errCnt;

    logic                               w_addrOk;
    logic                               w_execReject;
    logic                               w_busyDrop;
    logic                               w_errInc;
    logic [IDX_W-1:0]                   w_idx;
    logic                               w_unusedPayloadLsb;

    // payload[0] carries no brightness information
    assign w_unusedPayloadLsb = rx_frame[0];

    assign w_addrOk     = (32'(r_addr) < 32'(NUM_LEDS));
    assign w_idx        = r_addr[IDX_W-1:0];
    assign w_busyDrop   = rx_dv && (r_state != LC_IDLE);
    assign w_execReject = (r_state == LC_EXEC) &&
                          ((r_action == ACT_BAD) ||
                           (((r_action == ACT_SET) || (r_action == ACT_GET)) && !r_addrOk));
    // A busy-drop and an EXEC reject in the same cycle still count once
    assign w_errInc     = w_busyDrop || w_execReject;

    assign tx_frame = r_txFrame;
    assign tx_load  = r_txLoad;
    assign busy     = (r_state != LC_IDLE);
    assign err_cnt  = r_errCnt;

    // State register
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_state <= LC_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Fixed three-step walk; only IDLE looks at rx_dv
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            LC_IDLE:   if (rx_dv) w_nextState = LC_DECODE;
            LC_DECODE: w_nextState = LC_EXEC;
            LC_EXEC:   w_nextState = LC_IDLE;
            default:   w_nextState = LC_IDLE;
        endcase
    end

    // Frame latch, decode registers, brightness file, readback frame and
    // error counter. The decode result is registered in DECODE so EXEC acts
    // purely on stored values.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_cmd     <= '0;
            r_addr    <= '0;
            r_level   <= '0;
            r_action  <= ACT_NOP;
            r_addrOk  <= 1'b0;
            r_bright  <= '0;
            r_txFrame <= '0;
            r_txLoad  <= 1'b0;
            r_errCnt  <= '0;
        end else begin
            r_txLoad <= 1'b0;

            if ((r_state == LC_IDLE) && rx_dv) begin
                r_cmd   <= rx_frame[FRAME_W-1 -: CMD_BITS];
                r_addr  <= rx_frame[ADDR_BITS+PAYLOAD_BITS-1 -: ADDR_BITS];
                r_level <= rx_frame[PAYLOAD_BITS-1:1];
            end

            if (r_state == LC_DECODE) begin
                r_addrOk <= w_addrOk;
                r_action <= classifyCmd(r_cmd);
            end

            if (r_state == LC_EXEC) begin
                case (r_action)
                    ACT_SET: begin
                        if (r_addrOk) r_bright[w_idx] <= r_level;
                    end
                    ACT_GET: begin
                        r_txLoad  <= 1'b1;
                        r_txFrame <= FRAME_W'({CMD_LED_GET, r_addr,
                                     r_addrOk ? {r_bright[w_idx], 1'b0} : 8'hFF});
                    end
                    ACT_ALL_OFF: r_bright <= '0;
                    default: ;
                endcase
            end

            if (w_errInc && (r_errCnt != 8'hFF)) begin
                r_errCnt <= r_errCnt + 8'd1;
            end
        end
    end

    pwm_channel_bank #(
        .NUM_LEDS (NUM_LEDS),
        .PWM_DIV  (PWM_DIV)
    ) u_pwmBank (
        .sysclk   (sysclk),
        .rst      (rst),
        .i_bright (r_bright),
        .o_leds   (leds)
    );

endmodule

// File: tb/tb_led_cmd_pwm.sv
// ---------------------------------------------------------------------------
// tb_led_cmd_pwm
// Self-checking bench for led_cmd_pwm. A behavioural model tracks the
// frame pipeline as "executes two edges after acceptance" and the PWM as
// arithmetic on the number of clock edges since reset; a compare process
// checks every output against it on each falling edge. Directed sequences
// pin the model with hand-computed values, then random traffic follows.
// ---------------------------------------------------------------------------
module tb_led_cmd_pwm;

    localparam int DIV    = 4;
    localparam int NLED   = 8;
    localparam int PERIOD = 127 * DIV;

    logic        sysclk = 1'b0;
    logic        rst;
    logic        rx_dv;
    logic [23:0] rx_frame;
    logic [23:0] tx_frame;
    logic        tx_load;
    logic        busy;
    logic [7:0]  err_cnt;
    logic [7:0]  leds;

    int checks   = 0;
    int failures = 0;
    logic cmpOn  = 1'b0;

    // Behavioural model state
    int          mT;
    logic [6:0]  mBright [NLED];
    logic [6:0]  mShadow [NLED];
    logic [7:0]  mLeds;
    logic [23:0] mTx;
    logic        mTxLoad;
    logic [7:0]  mErr;
    logic        mPending;
    int          mExecEdge;
    logic [23:0] mFrame;

    // Measurement counters for windowed duty checks
    int cntLed [NLED];
    int cntLoad;

    always #5 sysclk = ~sysclk;

    led_cmd_pwm #(
        .NUM_LEDS (NLED),
        .PWM_DIV  (DIV),
        .FRAME_W  (24)
    ) dut (
        .sysclk   (sysclk),
        .rst      (rst),
        .rx_dv    (rx_dv),
        .rx_frame (rx_frame),
        .tx_frame (tx_frame),
        .tx_load  (tx_load),
        .busy     (busy),
        .err_cnt  (err_cnt),
        .leds     (leds)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mT = 0;
        for (int i = 0; i < NLED; i++) begin
            mBright[i] = '0;
            mShadow[i] = '0;
        end
        mLeds     = '0;
        mTx       = '0;
        mTxLoad   = 1'b0;
        mErr      = '0;
        mPending  = 1'b0;
        mExecEdge = 0;
        mFrame    = '0;
    endtask

    // One rising edge of the reference: outputs after edge number mT
    task automatic modelStep();
        int         pwmPre;
        logic       drop;
        logic       rej;
        logic [7:0] cmd;
        logic [7:0] addr;
        logic [7:0] pay;
        pwmPre = (mT / DIV) % 127;
        for (int i = 0; i < NLED; i++) mLeds[i] = (pwmPre < int'(mShadow[i]));
        if (((mT + 1) % PERIOD) == 0) begin
            for (int i = 0; i < NLED; i++) mShadow[i] = mBright[i];
        end
        drop    = rx_dv && mPending;
        rej     = 1'b0;
        mTxLoad = 1'b0;
        if (mPending && (mT == mExecEdge)) begin
            mPending = 1'b0;
            cmd  = mFrame[23:16];
            addr = mFrame[15:8];
            pay  = mFrame[7:0];
            if (cmd == 8'h01) begin
                if (addr < 8'd8) mBright[addr[2:0]] = pay[7:1];
                else rej = 1'b1;
            end else if (cmd == 8'h02) begin
                mTxLoad = 1'b1;
                if (addr < 8'd8) mTx = {8'h02, addr, mBright[addr[2:0]], 1'b0};
                else begin
                    mTx = {8'h02, addr, 8'hFF};
                    rej = 1'b1;
                end
            end else if (cmd == 8'h03) begin
                for (int i = 0; i < NLED; i++) mBright[i] = '0;
            end else if (cmd != 8'h00) begin
                rej = 1'b1;
            end
        end else if (!mPending && rx_dv) begin
            mPending  = 1'b1;
            mExecEdge = mT + 2;
            mFrame    = rx_frame;
        end
        if ((drop || rej) && (mErr != 8'hFF)) mErr = mErr + 8'd1;
        mT++;
    endtask

    initial forever begin
        @(posedge sysclk);
        if (!rst) modelStep();
    end

    // Every-cycle comparison of all outputs against the model
    initial forever begin
        @(negedge sysclk);
        if (cmpOn) begin
            checkOutput("cycle", {22'd0, tx_frame, tx_load, busy, err_cnt, leds},
                        {22'd0, mTx, mTxLoad, mPending, mErr, mLeds});
        end
    end

    // Drive one frame for a single cycle, starting and ending on a falling edge
    task automatic applyStimulus(input logic [23:0] f);
        rx_frame = f;
        rx_dv    = 1'b1;
        @(negedge sysclk);
        rx_dv    = 1'b0;
    endtask

    // Drive a frame and wait until its EXEC result is visible
    task automatic sendFrame(input logic [23:0] f);
        applyStimulus(f);
        repeat (2) @(negedge sysclk);
    endtask

    task automatic measure(input int n);
        for (int i = 0; i < NLED; i++) cntLed[i] = 0;
        cntLoad = 0;
        repeat (n) begin
            @(negedge sysclk);
            for (int i = 0; i < NLED; i++) if (leds[i]) cntLed[i]++;
            if (tx_load) cntLoad++;
        end
    endtask

    initial begin
        int total;
        int gap;
        int sel;
        logic [7:0] c;
        logic [7:0] a;

        rst      = 1'b1;
        rx_dv    = 1'b0;
        rx_frame = '0;
        modelReset();
        repeat (3) @(negedge sysclk);
        rst   = 1'b0;
        cmpOn = 1'b1;
        checkOutput("reset_state", {tx_frame, tx_load, busy, err_cnt, leds}, 42'd0);

        // NOP leaves everything dark and quiet for two periods
        applyStimulus(24'h000000);
        measure(2 * PERIOD);
        total = 0;
        for (int i = 0; i < NLED; i++) total += cntLed[i];
        checkOutput("nop_leds", total, 0);
        checkOutput("nop_txload", cntLoad, 0);
        checkOutput("nop_err", err_cnt, 8'd0);

        // Brightness 10 on led1
        sendFrame(24'h010014);
        sendFrame(24'h020000);
        checkOutput("get0_frame", tx_frame, 24'h020014);
        repeat (2 * PERIOD) @(negedge sysclk);
        measure(PERIOD);
        checkOutput("led1_duty", cntLed[0], 10 * DIV);

        // Full brightness on led8 and readback
        sendFrame(24'h0107FE);
        applyStimulus(24'h020700);
        @(negedge sysclk);
        checkOutput("get7_noload_early", tx_load, 1'b0);
        @(negedge sysclk);
        checkOutput("get7_frame", tx_frame, 24'h0207FE);
        checkOutput("get7_load", tx_load, 1'b1);
        @(negedge sysclk);
        checkOutput("get7_load_single", tx_load, 1'b0);
        repeat (2 * PERIOD) @(negedge sysclk);
        measure(PERIOD);
        checkOutput("led8_const", cntLed[7], PERIOD);
        checkOutput("led1_duty_again", cntLed[0], 10 * DIV);

        // Out-of-range address
        sendFrame(24'h0110FF);
        checkOutput("bad_set_err", err_cnt, 8'd1);
        sendFrame(24'h021000);
        checkOutput("bad_get_frame", tx_frame, 24'h0210FF);
        checkOutput("bad_get_err", err_cnt, 8'd2);

        // Back-to-back: second frame arrives while busy
        rx_frame = 24'h010140;
        rx_dv    = 1'b1;
        @(negedge sysclk);
        rx_frame = 24'h010280;
        @(negedge sysclk);
        rx_dv    = 1'b0;
        @(negedge sysclk);
        checkOutput("b2b_err", err_cnt, 8'd3);
        sendFrame(24'h020100);
        checkOutput("b2b_first_done", tx_frame, 24'h020140);
        sendFrame(24'h020200);
        checkOutput("b2b_second_dropped", tx_frame, 24'h020200);
        sendFrame(24'h035A5A);
        sendFrame(24'h020700);
        checkOutput("alloff_get7", tx_frame, 24'h020700);
        repeat (2 * PERIOD) @(negedge sysclk);
        measure(PERIOD);
        total = 0;
        for (int i = 0; i < NLED; i++) total += cntLed[i];
        checkOutput("alloff_leds", total, 0);

        // Reset asserted while a write to LED 3 sits in DECODE
        applyStimulus(24'h01037E);
        #1;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("async_reset", {tx_frame, tx_load, busy, err_cnt, leds}, 42'd0);
        repeat (2) @(negedge sysclk);
        rst = 1'b0;
        sendFrame(24'h020300);
        checkOutput("reset_no_write", tx_frame, 24'h020300);
        sendFrame(24'h010341);
        sendFrame(24'h020300);
        checkOutput("post_reset_write", tx_frame, 24'h020340);
        checkOutput("post_reset_err", err_cnt, 8'd0);

        // Random traffic, checked cycle by cycle against the model
        for (int k = 0; k < 300; k++) begin
            gap = $urandom_range(0, 4);
            repeat (gap) @(negedge sysclk);
            sel = $urandom_range(0, 9);
            if (sel == 0)      c = 8'h00;
            else if (sel <= 3) c = 8'h01;
            else if (sel <= 6) c = 8'h02;
            else if (sel == 7) c = 8'h03;
            else               c = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 255));
            else                           a = 8'($urandom_range(0, 7));
            applyStimulus({c, a, 8'($urandom_range(0, 255))});
        end
        repeat (PERIOD) @(negedge sysclk);

        // Continuous bad frames drive err_cnt into saturation
        rx_frame = 24'hAA0000;
        rx_dv    = 1'b1;
        repeat (300) @(negedge sysclk);
        rx_dv = 1'b0;
        repeat (4) @(negedge sysclk);
        checkOutput("err_saturate", err_cnt, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
